// File: rtl/mapu_host.sv
// mapu_host -- host-side sequencer for a 4x4 matrix APU.
//
// The host fills an 8-row operand buffer (A rows 0-3 at addresses 0-3,
// B rows 0-3 at addresses 4-7) while the block is idle, then pulses
// i_start. The block streams the eight operand rows to the APU over a
// valid/ready handshake, collects four result rows back over a second
// valid/ready handshake, and pulses o_done. A result row that does not
// arrive within TIMEOUT idle cycles aborts the operation and raises a
// sticky o_err. No arithmetic happens here; rows pass through bit-exact.
//
// Ports
//   clk, reset_n          clock; asynchronous active-low reset
//   i_start, i_op         start pulse and operation (0 = ADD, 1 = MULT)
//   i_we, i_waddr, i_wdata  operand row write (honoured in IDLE only)
//   i_raddr, o_rdata      combinational result row read
//   o_busy, o_done, o_err status: busy level, done pulse, sticky timeout
//   o_en, o_op            APU enable and operation select
//   o_vld, i_rdy, o_r0-3  operand row stream toward the APU
//   i_vld, o_rdy, i_r0-3  result row stream from the APU
// Rows are packed with element 0 in the least significant DATA_WIDTH bits.

module mapu_host #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 256
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_start,
    input  logic                    i_op,
    input  logic                    i_we,
    input  logic [2:0]              i_waddr,
    input  logic [4*DATA_WIDTH-1:0] i_wdata,
    input  logic [1:0]              i_raddr,
    output logic [4*DATA_WIDTH-1:0] o_rdata,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_err,
    output logic                    o_en,
    output logic                    o_op,
    output logic                    o_vld,
    input  logic                    i_rdy,
    output logic [DATA_WIDTH-1:0]   o_r0,
    output logic [DATA_WIDTH-1:0]   o_r1,
    output logic [DATA_WIDTH-1:0]   o_r2,
    output logic [DATA_WIDTH-1:0]   o_r3,
    input  logic                    i_vld,
    output logic                    o_rdy,
    input  logic [DATA_WIDTH-1:0]   i_r0,
    input  logic [DATA_WIDTH-1:0]   i_r1,
    input  logic [DATA_WIDTH-1:0]   i_r2,
    input  logic [DATA_WIDTH-1:0]   i_r3
);

    localparam int RW = 4 * DATA_WIDTH;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RECV = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state;
    state_t        next_state;

    logic [RW-1:0] opnd_mem [8];
    logic [RW-1:0] res_mem  [4];
    logic [2:0]    k;          // operand row being offered
    logic [1:0]    j;          // next result row slot
    logic [TW-1:0] tcnt;       // idle cycles since the last result row

    logic          start_acc;
    logic          xfer;
    logic          cap;
    logic          tmo_hit;
    logic [RW-1:0] snd_row;

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave one unassigned and infer a latch.
        next_state = state;
        o_busy     = 1'b0;
        o_en       = 1'b0;
        o_vld      = 1'b0;
        o_rdy      = 1'b0;
        o_done     = 1'b0;
        start_acc  = 1'b0;
        xfer       = 1'b0;
        cap        = 1'b0;
        tmo_hit    = 1'b0;

        unique case (state)
            IDLE: begin
                if (i_start) begin
                    start_acc  = 1'b1;
                    next_state = SEND;
                end
            end
            SEND: begin
                o_busy = 1'b1;
                o_en   = 1'b1;
                o_vld  = 1'b1;
                if (i_rdy) begin
                    xfer = 1'b1;
                    if (k == 3'd7) next_state = RECV;
                end
            end
            RECV: begin
                o_busy = 1'b1;
                o_en   = 1'b1;
                o_rdy  = 1'b1;
                if (i_vld) begin
                    cap = 1'b1;
                    if (j == 2'd3) next_state = DONE;
                end else if (tcnt >= TW'(TIMEOUT - 1)) begin
                    // This idle cycle brings the count to TIMEOUT, so the
                    // error lands exactly TIMEOUT cycles after the last row.
                    tmo_hit    = 1'b1;
                    next_state = IDLE;
                end
            end
            DONE: begin
                o_busy     = 1'b1;
                o_done     = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // ------------------------------------------------------------------
    // Buffers, counters and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: both buffers are small register files that must read
            // back as zero after reset, so they are cleared here rather than
            // left to a RAM macro with undefined power-up contents.
            for (int i = 0; i < 8; i++) opnd_mem[i] <= '0;
            for (int i = 0; i < 4; i++) res_mem[i]  <= '0;
            k     <= '0;
            j     <= '0;
            tcnt  <= '0;
            o_op  <= 1'b0;
            o_err <= 1'b0;
        end else begin
            if (state == IDLE && i_we) opnd_mem[i_waddr] <= i_wdata;

            if (start_acc) begin
                o_op  <= i_op;
                o_err <= 1'b0;
                k     <= '0;
                j     <= '0;
                tcnt  <= '0;
            end

            if (xfer) k <= k + 3'd1;

            if (cap) begin
                res_mem[j] <= {i_r3, i_r2, i_r1, i_r0};
                j          <= j + 2'd1;
                tcnt       <= '0;
            end else if (state == RECV && tcnt != TW'(TIMEOUT)) begin
                tcnt <= tcnt + TW'(1);
            end

            if (tmo_hit) o_err <= 1'b1;
        end
    end

    // Operand row is only driven while offered, so the APU bus idles at 0.
    assign snd_row = o_vld ? opnd_mem[k] : '0;
    assign o_r0    = snd_row[0*DATA_WIDTH +: DATA_WIDTH];
    assign o_r1    = snd_row[1*DATA_WIDTH +: DATA_WIDTH];
    assign o_r2    = snd_row[2*DATA_WIDTH +: DATA_WIDTH];
    assign o_r3    = snd_row[3*DATA_WIDTH +: DATA_WIDTH];

    assign o_rdata = res_mem[i_raddr];

endmodule

// File: tb/tb_mapu_host.sv
// Directed bench for mapu_host with TIMEOUT = 16. Inputs are driven and
// outputs sampled on the falling clock edge; the DUT acts on rising edges.
module tb_mapu_host;

    localparam int DW  = 32;
    localparam int RW  = 4 * DW;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          i_start = 1'b0;
    logic          i_op = 1'b0;
    logic          i_we = 1'b0;
    logic [2:0]    i_waddr = '0;
    logic [RW-1:0] i_wdata = '0;
    logic [1:0]    i_raddr = '0;
    logic [RW-1:0] o_rdata;
    logic          o_busy, o_done, o_err, o_en, o_op, o_vld, o_rdy;
    logic          i_rdy = 1'b0;
    logic          i_vld = 1'b0;
    logic [DW-1:0] o_r0, o_r1, o_r2, o_r3;
    logic [DW-1:0] i_r0 = '0, i_r1 = '0, i_r2 = '0, i_r3 = '0;

    int            checks = 0;
    int            errors = 0;
    logic [RW-1:0] exp_op [8];
    logic [RW-1:0] res_in [4];
    int            gap_in [4];

    mapu_host #(.DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_op(i_op),
        .i_we(i_we), .i_waddr(i_waddr), .i_wdata(i_wdata),
        .i_raddr(i_raddr), .o_rdata(o_rdata),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .o_en(o_en), .o_op(o_op), .o_vld(o_vld), .i_rdy(i_rdy),
        .o_r0(o_r0), .o_r1(o_r1), .o_r2(o_r2), .o_r3(o_r3),
        .i_vld(i_vld), .o_rdy(o_rdy),
        .i_r0(i_r0), .i_r1(i_r1), .i_r2(i_r2), .i_r3(i_r3)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [RW-1:0] rep(input logic [DW-1:0] v);
        return {v, v, v, v};
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic load_operands();
        logic [RW-1:0] row;
        for (int r = 0; r < 8; r++) begin
            row = '0;
            if (r < 4) row[r*DW +: DW] = 32'd1;
            else       row = {32'd4, 32'd3, 32'd2, 32'd1};
            exp_op[r] = row;
            i_we = 1'b1; i_waddr = 3'(r); i_wdata = row;
            cyc();
        end
        i_we = 1'b0;
    endtask

    task automatic start_op(input logic op);
        i_op = op; i_start = 1'b1;
        cyc();
        i_start = 1'b0;
    endtask

    // Called in the first SEND cycle. With toggle set, i_rdy runs 0,1,0,1...
    task automatic send_rows(input bit toggle);
        int n;
        int idx;
        n = toggle ? 16 : 8;
        for (int c = 1; c <= n; c++) begin
            idx   = toggle ? (c - 1) / 2 : c - 1;
            i_rdy = toggle ? (c % 2 == 0) : 1'b1;
            checks++;
            if (o_vld !== 1'b1 || {o_r3, o_r2, o_r1, o_r0} !== exp_op[idx]) begin
                errors++;
                $display("FAIL send_row c=%0d: vld=%b row=%h required vld=1 row=%h",
                         c, o_vld, {o_r3, o_r2, o_r1, o_r0}, exp_op[idx]);
            end
            cyc();
        end
        i_rdy = 1'b0;
        checks++;
        if (o_vld !== 1'b0 || o_rdy !== 1'b1) begin
            errors++;
            $display("FAIL send_end: vld=%b rdy=%b required vld=0 rdy=1", o_vld, o_rdy);
        end
    endtask

    task automatic recv_rows(input int ncap);
        for (int i = 0; i < ncap; i++) begin
            for (int g = 0; g < gap_in[i]; g++) begin
                checks++;
                if (o_rdy !== 1'b1 || o_done !== 1'b0) begin
                    errors++;
                    $display("FAIL recv_gap row=%0d: rdy=%b done=%b required rdy=1 done=0",
                             i, o_rdy, o_done);
                end
                cyc();
            end
            i_vld = 1'b1;
            {i_r3, i_r2, i_r1, i_r0} = res_in[i];
            cyc();
            i_vld = 1'b0;
        end
    endtask

    task automatic check_done_pulse(input string tag);
        checks++;
        if (o_done !== 1'b1 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL %s done: done=%b busy=%b required 1 1", tag, o_done, o_busy);
        end
        cyc();
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: done=%b busy=%b required 0 0", tag, o_done, o_busy);
        end
    endtask

    task automatic check_res(input string tag, input int ra, input logic [RW-1:0] exp);
        i_raddr = 2'(ra);
        #1;
        checks++;
        if (o_rdata !== exp) begin
            errors++;
            $display("FAIL %s raddr=%0d: rdata=%h required %h", tag, ra, o_rdata, exp);
        end
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        cyc(); cyc();
        checks++;
        if ({o_busy, o_done, o_err, o_en, o_op, o_vld, o_rdy} !== 7'b0) begin
            errors++;
            $display("FAIL reset_status: busy/done/err/en/op/vld/rdy=%b required 0000000",
                     {o_busy, o_done, o_err, o_en, o_op, o_vld, o_rdy});
        end
        checks++;
        if ({o_r3, o_r2, o_r1, o_r0} !== '0) begin
            errors++;
            $display("FAIL reset_row: row=%h required 0", {o_r3, o_r2, o_r1, o_r0});
        end
        reset_n = 1'b1;
        // Result rows offered while idle must be ignored.
        i_vld = 1'b1;
        {i_r3, i_r2, i_r1, i_r0} = rep(32'hFFFF_FFFF);
        cyc();
        i_vld = 1'b0;
        checks++;
        if (o_rdy !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_rdy: rdy=%b busy=%b required 0 0", o_rdy, o_busy);
        end
        check_res("idle_vld_ignored", 0, '0);
    endtask

    task automatic test_add();
        load_operands();
        start_op(1'b0);
        checks++;
        if (o_op !== 1'b0 || o_busy !== 1'b1 || o_en !== 1'b1) begin
            errors++;
            $display("FAIL add_start: op=%b busy=%b en=%b required 0 1 1", o_op, o_busy, o_en);
        end
        send_rows(1'b0);
        res_in[0] = rep(32'h10); res_in[1] = rep(32'h20);
        res_in[2] = rep(32'h30); res_in[3] = rep(32'h40);
        gap_in[0] = 0; gap_in[1] = 2; gap_in[2] = 5; gap_in[3] = 1;
        recv_rows(4);
        check_done_pulse("add");
        check_res("add_res", 2, rep(32'h30));
        check_res("add_res", 0, rep(32'h10));
        check_res("add_res", 3, rep(32'h40));
    endtask

    task automatic test_toggle();
        start_op(1'b1);
        checks++;
        if (o_op !== 1'b1) begin
            errors++;
            $display("FAIL toggle_op: op=%b required 1", o_op);
        end
        send_rows(1'b1);
        for (int i = 0; i < 4; i++) begin
            for (int e = 0; e < 4; e++) res_in[i][e*DW +: DW] = 32'h100 * (i + 1) + e;
            gap_in[i] = 0;
        end
        recv_rows(4);
        check_done_pulse("toggle");
        check_res("toggle_res", 1, {32'h203, 32'h202, 32'h201, 32'h200});
    endtask

    task automatic test_timeout();
        int early;
        start_op(1'b0);
        send_rows(1'b0);
        res_in[0] = rep(32'hA1); res_in[1] = rep(32'hA2);
        gap_in[0] = 0; gap_in[1] = 3;
        recv_rows(2);
        early = 0;
        for (int c = 1; c <= TMO - 1; c++) begin
            cyc();
            if (o_err !== 1'b0 || o_busy !== 1'b1) early++;
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL timeout_early: %0d early cycles required 0", early);
        end
        cyc();
        checks++;
        if (o_err !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_flag: err=%b busy=%b required 1 0", o_err, o_busy);
        end
        check_res("timeout_res", 0, rep(32'hA1));
        check_res("timeout_res", 1, rep(32'hA2));
        check_res("timeout_kept", 2, {32'h302, 32'h302, 32'h301, 32'h300} + {32'h1, 96'h0});
    endtask

    task automatic test_back_to_back();
        int pulses;
        start_op(1'b1);
        checks++;
        if (o_err !== 1'b0 || o_op !== 1'b1) begin
            errors++;
            $display("FAIL restart: err=%b op=%b required 0 1", o_err, o_op);
        end
        // Start and write attempts while SEND waits on i_rdy=0.
        i_start = 1'b1; i_op = 1'b0;
        i_we = 1'b1; i_waddr = 3'd0; i_wdata = '1;
        cyc();
        i_start = 1'b0; i_we = 1'b0;
        checks++;
        if (o_op !== 1'b1 || o_vld !== 1'b1) begin
            errors++;
            $display("FAIL send_ignore: op=%b vld=%b required 1 1", o_op, o_vld);
        end
        send_rows(1'b0);
        for (int i = 0; i < 4; i++) begin
            res_in[i] = rep(32'h55 + 32'(i));
            gap_in[i] = 0;
        end
        recv_rows(4);
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            if (o_done === 1'b1) pulses++;
            cyc();
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL done_count: %0d pulses required 1", pulses);
        end
    endtask

    task automatic test_reset_mid();
        start_op(1'b0);
        i_rdy = 1'b1;
        repeat (3) cyc();
        i_rdy = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (o_vld !== 1'b0 || o_en !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: vld=%b en=%b busy=%b required 0 0 0",
                     o_vld, o_en, o_busy);
        end
        for (int ra = 0; ra < 4; ra++) check_res("reset_res", ra, '0);
        cyc();
        reset_n = 1'b1;
        for (int r = 0; r < 8; r++) exp_op[r] = '0;
        start_op(1'b0);
        send_rows(1'b0);
        for (int i = 0; i < 4; i++) begin
            res_in[i] = rep(32'h7);
            gap_in[i] = 1;
        end
        recv_rows(4);
        check_done_pulse("after_reset");
    endtask

    initial begin
        test_reset();
        test_add();
        test_toggle();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
